// File: rtl/arith_sched.sv
// Job sequencer for the arithmetic pipeline: softmax (exp+sum then div replay), GeLU and AGG streams.
// Optional ARITH_SCHED_CHK_EN adds an err output and rejects op 3 / oversized softmax commands.
module arith_sched #(
  parameter int MAX_LEN   = 8,
  parameter int LEN_W     = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             dat_valid,
  output logic             dat_ready,
  input  logic [15:0]      dat_data,
  input  logic [15:0]      dat_psum,
  output logic             pipe_in_valid,
  output logic [15:0]      pipe_in_data,
  output logic [15:0]      pipe_in_psum,
  output logic [1:0]       pipe_in_mode,
  input  logic             pipe_out_valid,
  output logic             busy,
  output logic             done
`ifdef ARITH_SCHED_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(DRAIN_CYC + 2);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] DRAIN_L   = TMR_W'(DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_EXP, S_SETTLE, S_DIV, S_DRAIN, S_STREAM, S_WAIT_OUT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0]      buf_q [MAX_LEN];
  logic [IDX_W-1:0] idx;
  logic             dat_fire;
  logic             iss_valid;
  logic [15:0]      iss_data, iss_psum;
  logic [1:0]       iss_mode;
`ifdef ARITH_SCHED_CHK_EN
  logic             chk_q, chk_d, bad_cmd;
  assign bad_cmd = (cmd_op == 2'd3) || (cmd_op == 2'd0 && cmd_len > MAX_LEN_L);
`endif

  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign idx      = cnt_q[IDX_W-1:0];
  assign dat_fire = dat_valid && (state_q == S_EXP || state_q == S_STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      out_cnt_q     <= '0;
      timer_q       <= '0;
      pipe_in_valid <= 1'b0;
      pipe_in_data  <= '0;
      pipe_in_psum  <= '0;
      pipe_in_mode  <= '0;
`ifdef ARITH_SCHED_CHK_EN
      chk_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      out_cnt_q     <= out_cnt_d;
      timer_q       <= timer_d;
      pipe_in_valid <= iss_valid;
      // Data/psum/mode only move on an issue so the pipeline sees stable values during bubbles.
      if (iss_valid) begin
        pipe_in_data <= iss_data;
        pipe_in_psum <= iss_psum;
        pipe_in_mode <= iss_mode;
      end
`ifdef ARITH_SCHED_CHK_EN
      chk_q         <= chk_d;
`endif
    end
  end

  // Replay buffer holds the exp-pass operands for the div pass; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_EXP && dat_fire) buf_q[idx] <= dat_data;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    out_cnt_d = out_cnt_q;
`ifdef ARITH_SCHED_CHK_EN
    chk_d     = chk_q;
`endif
    if ((state_q == S_STREAM || state_q == S_WAIT_OUT) && pipe_out_valid && out_cnt_q != len_q)
      out_cnt_d = out_cnt_q + LEN_W'(1);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          len_d     = (cmd_op == 2'd0 && cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
          cnt_d     = '0;
          out_cnt_d = '0;
          if (cmd_len == '0)        state_d = S_DONE;
          else if (cmd_op == 2'd0)  state_d = S_EXP;
          else                      state_d = S_STREAM;
`ifdef ARITH_SCHED_CHK_EN
          chk_d = bad_cmd;
          if (bad_cmd) state_d = S_DONE;
`endif
        end
      end
      S_EXP: begin
        if (dat_fire) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_SETTLE;
            timer_d = DRAIN_L;
          end
        end
      end
      S_SETTLE: begin
        if (timer_q <= TMR_W'(1)) begin
          state_d = S_DIV;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_DIV: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = S_DRAIN;
          timer_d = DRAIN_L;
        end
      end
      S_DRAIN: begin
        if (timer_q <= TMR_W'(1)) state_d = S_DONE;
        else                      timer_d = timer_q - TMR_W'(1);
      end
      S_STREAM: begin
        if (dat_fire) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_WAIT_OUT;
        end
      end
      // A result arriving this cycle already counts, so done follows the last result by one cycle.
      S_WAIT_OUT: if (out_cnt_d == len_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = rst_n && (state_q == S_IDLE);
    dat_ready = (state_q == S_EXP) || (state_q == S_STREAM);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
`ifdef ARITH_SCHED_CHK_EN
    err       = chk_q && (state_q == S_DONE);
`endif
    iss_valid = 1'b0;
    iss_data  = pipe_in_data;
    iss_psum  = pipe_in_psum;
    iss_mode  = pipe_in_mode;
    case (state_q)
      S_EXP: begin
        if (dat_fire) begin
          iss_valid = 1'b1;
          iss_data  = dat_data;
          iss_mode  = 2'd0;
        end
      end
      S_DIV: begin
        iss_valid = 1'b1;
        iss_data  = buf_q[idx];
        iss_mode  = 2'd1;
      end
      S_STREAM: begin
        if (dat_fire) begin
          iss_valid = 1'b1;
          iss_data  = dat_data;
          if (op_q == 2'd2) begin
            iss_mode = 2'd3;
            iss_psum = dat_psum;
          end else begin
            iss_mode = 2'd2;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
